// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message padder: turns a byte stream into FIPS 180-4 padded
// 512-bit blocks with first/last markers for the hash core.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] out_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_first,
    output logic         out_last
);
    // Byte counter width: the bit length is count*8, so three bits fewer.
    localparam int CNT_W = LEN_W - 3;

    if (LEN_W != 64) begin : g_len_w_check
        $error("sha256_msg_padder: LEN_W must be 64");
    end

    typedef enum logic [1:0] {FILL, EMIT, TAIL} state_t;

    state_t           state_q, state_d;
    logic [511:0]     buf_q, buf_d;
    logic [5:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             pend_q, pend_d;
    logic             tail80_q, tail80_d;

    logic             accept;
    logic [8:0]       data_hi;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready  = (state_q == FILL) && !reset;
    assign accept    = in_valid && in_ready;
    assign data_hi   = 9'd511 - {idx_q, 3'b000};
    assign cnt_inc   = cnt_q + CNT_W'(1);

    assign out_valid = (state_q == EMIT);
    assign out_block = buf_q;
    assign out_first = (state_q == EMIT) && first_q;
    assign out_last  = (state_q == EMIT) && last_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        last_d   = last_q;
        pend_d   = pend_q;
        tail80_d = tail80_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d[data_hi -: 8] = in_data;
                    cnt_d = cnt_inc;
                    idx_d = idx_q + 6'd1;
                    if (in_last) begin
                        state_d = EMIT;
                        if (idx_q != 6'd63)
                            buf_d[data_hi - 9'd8 -: 8] = 8'h80;
                        if (idx_q <= 6'd54) begin
                            // Terminator and length both fit: this is the final block.
                            buf_d[LEN_W-1:0] = {cnt_inc, 3'b000};
                            last_d = 1'b1;
                            pend_d = 1'b0;
                        end else begin
                            last_d   = 1'b0;
                            pend_d   = 1'b1;
                            tail80_d = (idx_q == 6'd63);
                        end
                    end else if (idx_q == 6'd63) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                        pend_d  = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    first_d = last_q;
                    buf_d   = '0;
                    idx_d   = '0;
                    if (pend_q) begin
                        state_d = TAIL;
                    end else begin
                        if (last_q)
                            cnt_d = '0;
                        state_d = FILL;
                    end
                end
            end
            TAIL: begin
                buf_d = '0;
                if (tail80_q)
                    buf_d[511:504] = 8'h80;
                buf_d[LEN_W-1:0] = {cnt_q, 3'b000};
                last_d  = 1'b1;
                pend_d  = 1'b0;
                state_d = EMIT;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the block buffer is reset because it drives out_block, which must read zero after reset.
            state_q  <= FILL;
            buf_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            pend_q   <= 1'b0;
            tail80_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            tail80_q <= tail80_d;
        end
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Streaming transmitter side of the 512-bit block interface consumed by message_scheduler.
- Accepts a byte stream with valid/ready handshake and a last-byte marker.
- Emits FIPS 180-4 padded 512-bit blocks: 0x80 terminator, zero fill, 64-bit big-endian bit length.
- Hardware replacement for bench-side padding; messages may span any number of blocks, and the padder handles single- and double-block tails.

Parameters:
- LEN_W, 64, width of the bit-length field appended to the final block; fixed at 64 by SHA-256, kept as a parameter only for assertion checks.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  message byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  qualifies in_data as the final message byte; sampled only on accept.
- in_ready  output  1  padder can accept a byte this cycle.
- out_block  output  512  padded block; byte 0 in bits [511:504], byte 63 in bits [7:0].
- out_valid  output  1  out_block is valid.
- out_ready  input  1  downstream accepts out_block.
- out_first  output  1  block is the first of its message; hash core loads H_INIT.
- out_last  output  1  block is the final block; H after it is the digest.

Behaviour:
- Reset: out_valid=0, out_block=0, out_first=0, out_last=0; internal state FILL, byte index=0, byte count=0, buffer=0, first flag=1. in_ready=0 while reset is high.
- Byte accept: in_valid && in_ready. Byte k of the current block (k=0..63) is written to buffer[511-8k -: 8]. The byte counter increments by 1 and wraps modulo 2^61.
- States: FILL, EMIT, TAIL.
- FILL:
  - in_ready=1, out_valid=0.
  - Accept at k=63 with in_last=0: block full → EMIT, out_last=0.
  - Accept with in_last=1, with n=k+1 bytes in the buffer:
    - n<=55: place 0x80 at byte n, write length=(count+1)*8 into bits [63:0] → EMIT, out_last=1.
    - 56<=n<=63: place 0x80 at byte n; bits [63:0] remain data/zero → EMIT, out_last=0, tail_pending=1 (tail type zero+len).
    - n==64: no terminator → EMIT, out_last=0, tail_pending=1 (tail type 0x80+len).
- EMIT:
  - in_ready=0; out_valid=1; out_block=buffer; out_first=first flag.
  - Outputs are held stable while !out_ready.
  - On handshake: first flag←out_last. Buffer clears and k←0.
    - If tail_pending: → TAIL.
    - Else if out_last: count←0, → FILL.
    - Else → FILL.
- TAIL:
  - One cycle. Build buffer = zeros, with 0x80 at byte 0 when the tail type is 0x80+len, and the length in [63:0].
  - Then → EMIT with out_last=1, tail_pending=0.
- Latency:
  - out_valid rises the cycle after the accepting edge of byte 63 or the last byte.
  - A second tail block becomes valid 2 cycles after the first tail-block handshake.
- Length field is the bit count of the whole message (count*8), truncated to 64 bits.
- Minimum message length is 1 byte. A zero-length message is not representable, and the padder never emits an empty-message block.
- No byte is dropped under back-pressure: in_ready stays 0 in EMIT/TAIL.
- Reset mid-operation: all state and the partial buffer are discarded. Any pending output is dropped, and out_valid=0 the cycle after reset is sampled.

Test Plan:
1. "abc" (0x61,0x62,0x63; last on 0x63), out_ready=1 → one block 0x61626380_00…00_00000000_00000018; out_first=1, out_last=1; the following hash equals ba7816bf…f20015ad.
2. 55 bytes of 0x00, last on byte 55 → one block; byte 55=0x80; [63:0]=0x1B8; out_first=out_last=1.
3. 56 bytes of 0x61 → block 1: byte 56=0x80, [63:0]=0, out_first=1, out_last=0. Block 2: all zero except [63:0]=0x1C0, out_first=0, out_last=1.
4. 64 bytes of 0xFF → block 1: all 0xFF, out_last=0. Block 2: byte 0=0x80, [63:0]=0x200, out_last=1. Then 130 bytes → 3 blocks, length 0x410.
5. Back-pressure on "abc": out_ready=0 for 5 cycles → out_block and out_valid stable, in_ready=0 throughout. Exactly one handshake occurs, and the next message gets out_first=1.
6. Reset after 10 bytes of a message, then "abc" → output is identical to test 1, with no stale bytes or length carried over.
